// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared stream-source tags and arbiter state encoding
package axis_pkg;

  typedef logic axis_src_t;

  localparam axis_src_t SRC_S0 = 1'b0;
  localparam axis_src_t SRC_S1 = 1'b1;

  typedef enum logic {
    G0 = 1'b0,
    G1 = 1'b1
  } grant_state_t;

endpackage

// File: rtl/axis_merger_if.sv
// rtl/axis_merger_if.sv - two slave streams plus one master stream of the 2:1 merger
interface axis_merger_if #(
  parameter int DATA_W = 32
) ();

  logic              S0_AXIS_tvalid;
  logic [DATA_W-1:0] S0_AXIS_tdata;
  logic              S0_AXIS_tready;
  logic              S1_AXIS_tvalid;
  logic [DATA_W-1:0] S1_AXIS_tdata;
  logic              S1_AXIS_tready;
  logic              M_AXIS_tready;
  logic              M_AXIS_tvalid;
  logic [DATA_W-1:0] M_AXIS_tdata;
  logic              M_AXIS_tuser;

  // Merger side: consumes S0/S1, produces M.
  modport slave (
    input  S0_AXIS_tvalid, S0_AXIS_tdata,
    input  S1_AXIS_tvalid, S1_AXIS_tdata,
    input  M_AXIS_tready,
    output S0_AXIS_tready, S1_AXIS_tready,
    output M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tuser
  );

  // Environment side: producers on S0/S1 and the downstream sink.
  modport master (
    output S0_AXIS_tvalid, S0_AXIS_tdata,
    output S1_AXIS_tvalid, S1_AXIS_tdata,
    output M_AXIS_tready,
    input  S0_AXIS_tready, S1_AXIS_tready,
    input  M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tuser
  );

endinterface

// File: rtl/axis_rr_arbiter2.sv
// rtl/axis_rr_arbiter2.sv - two-requester round-robin arbiter owning last_grant
module axis_rr_arbiter2
  import axis_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  axis_src_t  src_in,
  output axis_src_t  sel,
  output logic       gnt_valid
);

  grant_state_t state_q;
  grant_state_t state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= G1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel       = SRC_S0;
    gnt_valid = |req;
    case (req)
      2'b01:   sel = SRC_S0;
      2'b10:   sel = SRC_S1;
      // On a tie the requester that did not win last goes next.
      2'b11:   sel = (state_q == G1) ? SRC_S0 : SRC_S1;
      default: sel = SRC_S0;
    endcase
    if (advance) begin
      state_d = (src_in == SRC_S1) ? G1 : G0;
    end
  end

endmodule

// File: rtl/axis_merger.sv
// rtl/axis_merger.sv - round-robin 2:1 AXI4-Stream merger with registered output and beat counters
module axis_merger
  import axis_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                 aclk,
  input  logic                 reset,
  axis_merger_if.slave         bus,
  output logic [CNT_WIDTH-1:0] count0,
  output logic [CNT_WIDTH-1:0] count1
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                        m_tvalid_q;
  logic [AXIS_TDATA_WIDTH-1:0] m_tdata_q;
  axis_src_t                   m_tuser_q;

  logic      load;
  logic      gnt_valid;
  logic      xfer;
  axis_src_t sel;

  assign load = !m_tvalid_q || bus.M_AXIS_tready;

  axis_rr_arbiter2 u_arb (
    .clk       (aclk),
    .reset     (reset),
    .req       ({bus.S1_AXIS_tvalid, bus.S0_AXIS_tvalid}),
    .advance   (xfer),
    .src_in    (sel),
    .sel       (sel),
    .gnt_valid (gnt_valid)
  );

  assign bus.S0_AXIS_tready = !reset && load && (sel == SRC_S0);
  assign bus.S1_AXIS_tready = !reset && load && (sel == SRC_S1);

  // When any slave is valid, sel points at a valid one, so this is exactly its handshake.
  assign xfer = !reset && load && gnt_valid;

  always_ff @(posedge aclk) begin
    if (reset) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= SRC_S0;
    end else if (load) begin
      m_tvalid_q <= xfer;
      if (xfer) begin
        m_tdata_q <= (sel == SRC_S1) ? bus.S1_AXIS_tdata : bus.S0_AXIS_tdata;
        m_tuser_q <= sel;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      count0 <= '0;
      count1 <= '0;
    end else if (xfer) begin
      if (sel == SRC_S1) begin
        count1 <= count1 + CNT_ONE;
      end else begin
        count0 <= count0 + CNT_ONE;
      end
    end
  end

  assign bus.M_AXIS_tvalid = m_tvalid_q;
  assign bus.M_AXIS_tdata  = m_tdata_q;
  assign bus.M_AXIS_tuser  = m_tuser_q;

endmodule

// File: tb/tb_axis_merger.sv
// tb/tb_axis_merger.sv - directed scoreboard bench for axis_merger
module tb_axis_merger;

  logic       aclk;
  logic       reset;
  logic [3:0] count0;
  logic [3:0] count1;

  axis_merger_if #(.DATA_W(32)) bus ();

  axis_merger #(
    .AXIS_TDATA_WIDTH (32),
    .CNT_WIDTH        (4)
  ) dut (
    .aclk   (aclk),
    .reset  (reset),
    .bus    (bus),
    .count0 (count0),
    .count1 (count1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errs   = 0;

  logic [31:0] src0_q[$];
  logic [31:0] src1_q[$];
  logic [32:0] sb[$];
  logic        obs_user[$];

  logic       rst;
  logic       m_ready;
  logic       exp_mv;
  logic       lg;
  logic [3:0] e0;
  logic [3:0] e1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    reset              = rst;
    bus.S0_AXIS_tvalid = (src0_q.size() != 0);
    bus.S0_AXIS_tdata  = (src0_q.size() != 0) ? src0_q[0] : 32'h0;
    bus.S1_AXIS_tvalid = (src1_q.size() != 0);
    bus.S1_AXIS_tdata  = (src1_q.size() != 0) ? src1_q[0] : 32'h0;
    bus.M_AXIS_tready  = m_ready;
  endtask

  // One clock: drive, check at the falling edge against the model, advance the model.
  task automatic cycle();
    logic v0, v1, ld, s, er0, er1;
    apply();
    @(negedge aclk);
    v0  = (src0_q.size() != 0);
    v1  = (src1_q.size() != 0);
    ld  = !exp_mv || m_ready;
    s   = (v0 && !v1) ? 1'b0 : (v1 && !v0) ? 1'b1 : (v0 && v1) ? !lg : 1'b0;
    er0 = !rst && ld && (s == 1'b0);
    er1 = !rst && ld && (s == 1'b1);
    chk("s0_tready", {31'b0, bus.S0_AXIS_tready}, {31'b0, er0});
    chk("s1_tready", {31'b0, bus.S1_AXIS_tready}, {31'b0, er1});
    chk("m_tvalid", {31'b0, bus.M_AXIS_tvalid}, {31'b0, exp_mv});
    chk("count0", {28'b0, count0}, {28'b0, e0});
    chk("count1", {28'b0, count1}, {28'b0, e1});
    if (exp_mv) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        chk("m_tdata", bus.M_AXIS_tdata, sb[0][31:0]);
        chk("m_tuser", {31'b0, bus.M_AXIS_tuser}, {31'b0, sb[0][32]});
      end
      if (m_ready) obs_user.push_back(bus.M_AXIS_tuser);
    end
    if (rst) begin
      exp_mv = 1'b0;
      e0 = 4'd0;
      e1 = 4'd0;
      lg = 1'b1;
      sb.delete();
    end else if (ld) begin
      if (exp_mv && m_ready && sb.size() != 0) void'(sb.pop_front());
      if (er0 && v0) begin
        sb.push_back({1'b0, src0_q.pop_front()});
        exp_mv = 1'b1;
        lg = 1'b0;
        e0 = e0 + 4'd1;
      end else if (er1 && v1) begin
        sb.push_back({1'b1, src1_q.pop_front()});
        exp_mv = 1'b1;
        lg = 1'b1;
        e1 = e1 + 4'd1;
      end else begin
        exp_mv = 1'b0;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m_ready = 1'b1;
    exp_mv = 1'b0;
    lg = 1'b1;
    e0 = 4'd0;
    e1 = 4'd0;
    apply();
    @(posedge aclk);
    #1;

    // 1: reset held with both slaves valid
    src0_q = '{32'h1, 32'h2};
    src1_q = '{32'h3};
    repeat (3) cycle();
    src0_q.delete();
    src1_q.delete();
    rst = 1'b0;
    cycle();

    // 2: S0 only
    src0_q = '{32'h11, 32'h22, 32'h33};
    repeat (5) cycle();
    chk("t2_count0", {28'b0, count0}, 32'd3);
    chk("t2_count1", {28'b0, count1}, 32'd0);

    // 3: both slaves valid, grants alternate starting with S0 after reset
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    obs_user.delete();
    for (int i = 0; i < 4; i++) begin
      src0_q.push_back(32'hA0 + i);
      src1_q.push_back(32'hB0 + i);
    end
    repeat (10) cycle();
    chk("t3_beats", obs_user.size(), 32'd8);
    for (int i = 0; i < 8 && i < obs_user.size(); i++) begin
      chk("t3_tuser_seq", {31'b0, obs_user[i]}, i % 2);
    end
    chk("t3_count0", {28'b0, count0}, 32'd4);
    chk("t3_count1", {28'b0, count1}, 32'd4);

    // 4: backpressure while M holds 0xDEAD
    src0_q = '{32'hDEAD};
    cycle();
    m_ready = 1'b0;
    src0_q = '{32'h1001};
    src1_q = '{32'h2002};
    repeat (5) cycle();
    chk("t4_hold_data", bus.M_AXIS_tdata, 32'hDEAD);
    chk("t4_hold_valid", {31'b0, bus.M_AXIS_tvalid}, 32'd1);
    m_ready = 1'b1;
    repeat (4) cycle();
    chk("t4_drained", sb.size() + src0_q.size() + src1_q.size(), 32'd0);
    chk("t4_count0", {28'b0, count0}, 32'd6);
    chk("t4_count1", {28'b0, count1}, 32'd5);

    // 5: 4-bit counter wraps after 17 S1 beats
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) src1_q.push_back(32'hC00 + i);
    repeat (19) cycle();
    chk("t5_count1_wrap", {28'b0, count1}, 32'd1);

    // 6: reset with a stalled pending word, then a tie goes to S0
    src0_q = '{32'h66};
    m_ready = 1'b0;
    cycle();
    chk("t6_pending", {31'b0, bus.M_AXIS_tvalid}, 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_tvalid_dropped", {31'b0, bus.M_AXIS_tvalid}, 32'd0);
    src0_q = '{32'h70};
    src1_q = '{32'h71};
    m_ready = 1'b1;
    cycle();
    chk("t6_first_tuser", {31'b0, bus.M_AXIS_tuser}, 32'd0);
    chk("t6_first_tdata", bus.M_AXIS_tdata, 32'h70);
    repeat (3) cycle();
    chk("t6_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
